xoodyak_absorb_packer: RTL

Byte-serial message front end for the Xoodyak hash core. It sits directly between the top-level `msg`/`msg_len`/`start`/`busy` pins and the Xoodoo absorb datapath. It accumulates incoming message bytes into rate-sized blocks (16 bytes in hash mode), marks first and last blocks, reports each block's byte count, and holds the byte source off with `busy` until the datapath accepts the block.

---
 rtl/xoodyak_pkg.sv | 15 +
 rtl/xoodyak_absorb_packer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/xoodyak_pkg.sv
// Shared Xoodyak constants and the absorb-stage state encoding.
// Used by the packer, the absorb datapath and the squeeze stage.
package xoodyak_pkg;

  localparam int RATE_HASH = 16;
  localparam logic [7:0] CD_ABSORB_HASH = 8'h03;
  localparam logic [7:0] PAD_BYTE = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } absorb_st_t;

endpackage

// File: rtl/xoodyak_absorb_packer.sv
// Byte-serial front end: packs message bytes into rate-sized absorb blocks.
// state   | meaning
// IDLE    | waiting for start
// LOAD    | capturing one msg byte per cycle into the block buffer
// EMIT    | block presented to the datapath; source held off with busy
module xoodyak_absorb_packer
  import xoodyak_pkg::*;
#(
  parameter int RATE_BYTES = RATE_HASH,
  parameter int LEN_W      = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              msg,
  input  logic [LEN_W-1:0]        msg_len,
  output logic                    busy,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [8*RATE_BYTES-1:0] blk_data,
  output logic [4:0]              blk_nbytes,
  output logic                    blk_first,
  output logic                    blk_last,
  output logic                    absorb_done
);

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [3:0]       IDX_LAST = 4'(RATE_BYTES - 1);

  absorb_st_t state, state_n;
  logic [LEN_W-1:0]        remaining, remaining_n;
  logic [3:0]              idx, idx_n;
  logic [8*RATE_BYTES-1:0] buffer, buffer_n;
  logic [4:0]              nbytes, nbytes_n;
  logic                    first, first_n;
  logic                    last, last_n;
  logic                    emit, emit_n;
  logic                    done, done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      idx       <= '0;
      buffer    <= '0;
      nbytes    <= '0;
      first     <= 1'b0;
      last      <= 1'b0;
      emit      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      idx       <= idx_n;
      buffer    <= buffer_n;
      nbytes    <= nbytes_n;
      first     <= first_n;
      last      <= last_n;
      emit      <= emit_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    idx_n       = idx;
    buffer_n    = buffer;
    nbytes_n    = nbytes;
    first_n     = first;
    last_n      = last;
    emit_n      = emit;
    done_n      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          remaining_n = msg_len;
          idx_n       = '0;
          first_n     = 1'b1;
          buffer_n    = '0;
          if (msg_len == '0) begin
            state_n  = ST_EMIT;
            nbytes_n = 5'd0;
            last_n   = 1'b1;
            emit_n   = 1'b1;
          end else begin
            state_n = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        buffer_n[8*idx +: 8] = msg;
        idx_n       = idx + 4'd1;
        remaining_n = remaining - LEN_ONE;
        if (idx == IDX_LAST || remaining == LEN_ONE) begin
          // idx restarts here so it never wraps through the 4-bit range
          state_n  = ST_EMIT;
          idx_n    = '0;
          nbytes_n = 5'(idx) + 5'd1;
          last_n   = (remaining == LEN_ONE);
          emit_n   = 1'b1;
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          buffer_n = '0;
          idx_n    = '0;
          first_n  = 1'b0;
          last_n   = 1'b0;
          emit_n   = 1'b0;
          if (last) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_LOAD;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        emit_n  = 1'b0;
      end
    endcase
  end

  assign busy        = emit;
  assign blk_valid   = emit;
  assign blk_data    = buffer;
  assign blk_nbytes  = nbytes;
  assign blk_first   = first;
  assign blk_last    = last;
  assign absorb_done = done;

endmodule
